// File: rtl/rtc_pkg.sv
// Shared types and defaults for the stopwatch sequencer (optional lap feature: RTC_LAP_EN).
// Latency: none (types and constants only).
// Backpressure: none.
package rtc_pkg;

    localparam int COUNT_W_DEF      = 24;
    localparam int CLK_PER_TICK_DEF = 1000000;   // i_sclk cycles per 10-ms tick

    // The LAP encoding exists only when the lap feature is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
`ifdef RTC_LAP_EN
        ,
        LAP  = 2'd3
`endif
    } rtc_state_e;

endpackage

// File: rtl/rtc_tick_gen.sv
// Prescaler: strobes tick once every CLK_PER_TICK enabled cycles; holds when disabled, clears on clr.
// Latency: tick is asserted during the enabled cycle in which the count wraps.
// Backpressure: none; enb freezes the count, so a paused period resumes where it left off.
// Ports: i_sclk/i_reset_n clock and async active-low reset; enb count enable; clr sync clear; tick strobe.
module rtc_tick_gen
    import rtc_pkg::*;
#(
    parameter int CLK_PER_TICK = CLK_PER_TICK_DEF
) (
    input  logic i_sclk,
    input  logic i_reset_n,
    input  logic enb,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enb) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Decode of the registered count qualified by the enable, so the strobe
    // sits exactly in the cycle whose edge performs the wrap.
    assign tick = enb && (cnt == LAST);

endmodule

// File: rtl/rtc_sequencer.sv
// Stopwatch control FSM (IDLE/RUN/LAP/STOP) driving an external counter; lap feature under RTC_LAP_EN.
// Latency: state-derived outputs change one cycle after the start/lap pulse edge; o_tick as prescaler.
// Backpressure: none; all-ones i_count forces STOP and blocks restart until cleared through IDLE.
// Ports: i_sclk, i_reset_n (async, active-low); i_start_p, i_lap_p one-cycle presses; i_count external
//        count; o_count_init clear request; o_count_enb counting; o_tick increment strobe;
//        o_disp_sel live/lap display select; o_lap_value captured lap; o_overflow sticky overflow.
module rtc_sequencer
    import rtc_pkg::*;
#(
    parameter int CLK_PER_TICK = CLK_PER_TICK_DEF,
    parameter int COUNT_W      = COUNT_W_DEF
) (
    input  logic               i_sclk,
    input  logic               i_reset_n,
    input  logic               i_start_p,
    input  logic               i_lap_p,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_count_init,
    output logic               o_count_enb,
    output logic               o_tick,
    output logic               o_disp_sel,
    output logic [COUNT_W-1:0] o_lap_value,
    output logic               o_overflow
);

    rtc_state_e state;
    logic       init_q;
    logic       enb_q;
    logic       ovf_q;
    logic       ovf_hit;
    logic       tick_enb;
    logic       tick_clr;

`ifdef RTC_LAP_EN
    logic               disp_q;
    logic [COUNT_W-1:0] lap_q;
`endif

    // enb_q is high exactly in RUN/LAP, so this is "counting and the count is saturated".
    assign ovf_hit  = enb_q && (&i_count);
    // The saturating cycle neither strobes nor advances the prescaler.
    assign tick_enb = enb_q && !ovf_hit;
    assign tick_clr = (state == IDLE);

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            init_q <= 1'b1;
            enb_q  <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef RTC_LAP_EN
            disp_q <= 1'b0;
            lap_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start_p) begin
                        state  <= RUN;
                        init_q <= 1'b0;
                        enb_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // Overflow outranks both presses; start outranks lap.
                    if (ovf_hit || i_start_p) begin
                        state <= STOP;
                        enb_q <= 1'b0;
                        if (ovf_hit) ovf_q <= 1'b1;
                    end
`ifdef RTC_LAP_EN
                    else if (i_lap_p) begin
                        state  <= LAP;
                        disp_q <= 1'b1;
                        lap_q  <= i_count;
                    end
`endif
                end
`ifdef RTC_LAP_EN
                LAP: begin
                    if (ovf_hit || i_start_p) begin
                        state  <= STOP;
                        enb_q  <= 1'b0;
                        disp_q <= 1'b0;
                        if (ovf_hit) ovf_q <= 1'b1;
                    end else if (i_lap_p) begin
                        state  <= RUN;
                        disp_q <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    // A latched overflow blocks restart; only clearing via IDLE recovers.
                    if (i_start_p && !ovf_q) begin
                        state <= RUN;
                        enb_q <= 1'b1;
                    end else if (i_lap_p) begin
                        state  <= IDLE;
                        init_q <= 1'b1;
                        ovf_q  <= 1'b0;
`ifdef RTC_LAP_EN
                        lap_q  <= '0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    init_q <= 1'b1;
                    enb_q  <= 1'b0;
                end
            endcase
        end
    end

    rtc_tick_gen #(
        .CLK_PER_TICK (CLK_PER_TICK)
    ) u_tick_gen (
        .i_sclk    (i_sclk),
        .i_reset_n (i_reset_n),
        .enb       (tick_enb),
        .clr       (tick_clr),
        .tick      (o_tick)
    );

    assign o_count_init = init_q;
    assign o_count_enb  = enb_q;
    assign o_overflow   = ovf_q;
`ifdef RTC_LAP_EN
    assign o_disp_sel   = disp_q;
    assign o_lap_value  = lap_q;
`else
    assign o_disp_sel   = 1'b0;
    assign o_lap_value  = '0;
`endif

endmodule

// File: tb/tb_rtc_sequencer.sv
// Directed bench for rtc_sequencer with CLK_PER_TICK=4, COUNT_W=24; lap expectations follow RTC_LAP_EN.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_rtc_sequencer;

`ifdef RTC_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        i_sclk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_start_p = 1'b0;
    logic        i_lap_p = 1'b0;
    logic [23:0] i_count = 24'h0;
    logic        o_count_init;
    logic        o_count_enb;
    logic        o_tick;
    logic        o_disp_sel;
    logic [23:0] o_lap_value;
    logic        o_overflow;

    int checks = 0;
    int failures = 0;

    rtc_sequencer #(
        .CLK_PER_TICK (4),
        .COUNT_W      (24)
    ) dut (
        .i_sclk       (i_sclk),
        .i_reset_n    (i_reset_n),
        .i_start_p    (i_start_p),
        .i_lap_p      (i_lap_p),
        .i_count      (i_count),
        .o_count_init (o_count_init),
        .o_count_enb  (o_count_enb),
        .o_tick       (o_tick),
        .o_disp_sel   (o_disp_sel),
        .o_lap_value  (o_lap_value),
        .o_overflow   (o_overflow)
    );

    always #5 i_sclk = ~i_sclk;

    task automatic step();
        @(posedge i_sclk);
        #1;
    endtask

    task automatic pulse_start();
        i_start_p = 1'b1;
        step();
        i_start_p = 1'b0;
    endtask

    task automatic pulse_lap();
        i_lap_p = 1'b1;
        step();
        i_lap_p = 1'b0;
    endtask

    task automatic do_reset();
        i_start_p = 1'b0;
        i_lap_p   = 1'b0;
        i_count   = 24'h0;
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b1;
        #2;
        i_reset_n = 1'b0;
        step();
        checks++; if (o_count_init !== 1'b1) begin failures++; $display("FAIL rst_init got=%b exp=1", o_count_init); end
        checks++; if (o_count_enb !== 1'b0) begin failures++; $display("FAIL rst_enb got=%b exp=0", o_count_enb); end
        checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", o_tick); end
        checks++; if (o_disp_sel !== 1'b0) begin failures++; $display("FAIL rst_disp got=%b exp=0", o_disp_sel); end
        checks++; if (o_lap_value !== 24'h0) begin failures++; $display("FAIL rst_lap got=%h exp=000000", o_lap_value); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", o_overflow); end
        i_reset_n = 1'b1;
        step();
        // IDLE ignores lap
        pulse_lap();
        checks++; if (o_count_init !== 1'b1 || o_count_enb !== 1'b0) begin failures++; $display("FAIL idle_lap init=%b enb=%b exp init=1 enb=0", o_count_init, o_count_enb); end
    endtask

    task automatic test_tick();
        do_reset();
        pulse_start();
        checks++; if (o_count_init !== 1'b0 || o_count_enb !== 1'b1) begin failures++; $display("FAIL start_run init=%b enb=%b exp init=0 enb=1", o_count_init, o_count_enb); end
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (o_tick !== ((k % 4) == 0)) begin failures++; $display("FAIL tick_cycle%0d got=%b exp=%b", k, o_tick, ((k % 4) == 0)); end
            step();
        end
        pulse_start();
        checks++; if (o_count_enb !== 1'b0 || o_count_init !== 1'b0) begin failures++; $display("FAIL run_stop enb=%b init=%b exp enb=0 init=0", o_count_enb, o_count_init); end
        pulse_lap();
        checks++; if (o_count_init !== 1'b1 || o_count_enb !== 1'b0) begin failures++; $display("FAIL stop_idle init=%b enb=%b exp init=1 enb=0", o_count_init, o_count_enb); end
    endtask

    task automatic test_lap();
        do_reset();
        i_count = 24'h000123;
        pulse_start();                 // enabled cycle 1
        pulse_lap();                   // enabled cycle 2
        checks++; if (o_disp_sel !== LAP_EN) begin failures++; $display("FAIL lap_disp got=%b exp=%b", o_disp_sel, LAP_EN); end
        checks++; if (o_lap_value !== (LAP_EN ? 24'h000123 : 24'h0)) begin failures++; $display("FAIL lap_value got=%h exp=%h", o_lap_value, (LAP_EN ? 24'h000123 : 24'h0)); end
        checks++; if (o_count_enb !== 1'b1) begin failures++; $display("FAIL lap_enb got=%b exp=1", o_count_enb); end
        i_count = 24'h000456;
        pulse_lap();                   // enabled cycle 3
        checks++; if (o_disp_sel !== 1'b0 || o_count_enb !== 1'b1) begin failures++; $display("FAIL lap2 disp=%b enb=%b exp disp=0 enb=1", o_disp_sel, o_count_enb); end
        checks++; if (o_lap_value !== (LAP_EN ? 24'h000123 : 24'h0)) begin failures++; $display("FAIL lap_hold got=%h exp=%h", o_lap_value, (LAP_EN ? 24'h000123 : 24'h0)); end
        step();                        // enabled cycle 4
        checks++; if (o_tick !== 1'b1) begin failures++; $display("FAIL lap_tick got=%b exp=1", o_tick); end
    endtask

    task automatic test_resume();
        do_reset();
        pulse_start();                 // enabled cycle 1
        step();                        // enabled cycle 2
        pulse_start();                 // STOP with prescaler at 2
        checks++; if (o_count_enb !== 1'b0 || o_tick !== 1'b0) begin failures++; $display("FAIL pause enb=%b tick=%b exp 0 0", o_count_enb, o_tick); end
        for (int k = 0; k < 10; k++) step();
        checks++; if (o_count_enb !== 1'b0 || o_tick !== 1'b0) begin failures++; $display("FAIL paused enb=%b tick=%b exp 0 0", o_count_enb, o_tick); end
        pulse_start();                 // resume cycle 1
        checks++; if (o_count_enb !== 1'b1 || o_tick !== 1'b0) begin failures++; $display("FAIL resume1 enb=%b tick=%b exp enb=1 tick=0", o_count_enb, o_tick); end
        step();
        checks++; if (o_tick !== 1'b1) begin failures++; $display("FAIL resume2_tick got=%b exp=1", o_tick); end
        step();
        checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL resume3_tick got=%b exp=0", o_tick); end
    endtask

    task automatic test_start_lap();
        do_reset();
        i_count = 24'h000777;
        pulse_start();
        pulse_lap();                   // capture 0x777 when lap is built in
        pulse_lap();                   // back to RUN
        i_count = 24'h000888;
        i_start_p = 1'b1;
        i_lap_p   = 1'b1;
        step();
        i_start_p = 1'b0;
        i_lap_p   = 1'b0;
        checks++; if (o_count_enb !== 1'b0 || o_disp_sel !== 1'b0) begin failures++; $display("FAIL both_stop enb=%b disp=%b exp 0 0", o_count_enb, o_disp_sel); end
        checks++; if (o_lap_value !== (LAP_EN ? 24'h000777 : 24'h0)) begin failures++; $display("FAIL both_nocap got=%h exp=%h", o_lap_value, (LAP_EN ? 24'h000777 : 24'h0)); end
        pulse_lap();
        checks++; if (o_count_init !== 1'b1 || o_lap_value !== 24'h0) begin failures++; $display("FAIL stop_lap_idle init=%b lap=%h exp init=1 lap=000000", o_count_init, o_lap_value); end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_start();                 // enabled cycle 1
        step();
        step();
        step();                        // enabled cycle 4, would tick
        i_count = 24'hFFFFFF;
        #1;
        checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL ovf_tick_suppress got=%b exp=0", o_tick); end
        step();
        i_count = 24'h0;
        #1;
        checks++; if (o_count_enb !== 1'b0 || o_overflow !== 1'b1 || o_tick !== 1'b0) begin failures++; $display("FAIL ovf_stop enb=%b ovf=%b tick=%b exp 0 1 0", o_count_enb, o_overflow, o_tick); end
        pulse_start();
        checks++; if (o_count_enb !== 1'b0 || o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_start_ignored enb=%b ovf=%b exp 0 1", o_count_enb, o_overflow); end
        pulse_lap();
        checks++; if (o_count_init !== 1'b1 || o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear init=%b ovf=%b exp 1 0", o_count_init, o_overflow); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_count = 24'h000123;
        pulse_start();                 // enabled cycle 1
        pulse_lap();                   // enabled cycle 2 (LAP when built in)
        step();
        step();                        // enabled cycle 4
        checks++; if (o_tick !== 1'b1 || o_disp_sel !== LAP_EN) begin failures++; $display("FAIL prereset tick=%b disp=%b exp tick=1 disp=%b", o_tick, o_disp_sel, LAP_EN); end
        #3;
        i_reset_n = 1'b0;
        #1;                            // well before the next rising edge
        checks++; if (o_count_init !== 1'b1 || o_count_enb !== 1'b0 || o_tick !== 1'b0) begin failures++; $display("FAIL async_ctl init=%b enb=%b tick=%b exp 1 0 0", o_count_init, o_count_enb, o_tick); end
        checks++; if (o_disp_sel !== 1'b0 || o_lap_value !== 24'h0 || o_overflow !== 1'b0) begin failures++; $display("FAIL async_dat disp=%b lap=%h ovf=%b exp 0 000000 0", o_disp_sel, o_lap_value, o_overflow); end
        #2;
        i_reset_n = 1'b1;
        i_count = 24'h0;
        step();
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (o_tick !== (k == 4)) begin failures++; $display("FAIL restart_tick%0d got=%b exp=%b", k, o_tick, (k == 4)); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_lap();
        test_resume();
        test_start_lap();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_sequencer.md
RTC_SEQUENCER -- requirements
Module: rtc_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 1000000, i_sclk cycles per 10-ms tick (minimum 2).
REQ-002 SHALL have parameter COUNT_W, default 24, width of the external stopwatch count.
REQ-003 i_sclk  input  1  system clock; all state changes on rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_start_p  input  1  debounced start/stop press, one-cycle pulse.
REQ-006 i_lap_p  input  1  debounced lap/clear press, one-cycle pulse.
REQ-007 i_count  input  COUNT_W  current value of the external counter.
REQ-008 o_count_init  output  1  synchronous clear request to the external counter.
REQ-009 o_count_enb  output  1  counting permitted.
REQ-010 o_tick  output  1  one-cycle increment strobe to the external counter, every CLK_PER_TICK enabled cycles.
REQ-011 o_disp_sel  output  1  0 = display live count, 1 = display lap value.
REQ-012 o_lap_value  output  COUNT_W  captured lap count.
REQ-013 o_overflow  output  1  sticky; count reached all-ones.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, LAP, STOP; all outputs registered.
REQ-015 IDLE: o_count_init=1, o_count_enb=0, o_disp_sel=0; start -> RUN; lap ignored.
REQ-016 RUN: init=0, enb=1, disp_sel=0; start -> STOP; lap -> LAP, with i_count captured into o_lap_value on the same edge.
REQ-017 LAP: init=0, enb=1, disp_sel=1; counting continues; start -> STOP (disp_sel=0); lap -> RUN.
REQ-018 STOP: init=0, enb=0, disp_sel=0; start -> RUN; lap -> IDLE.
REQ-019 Start and lap pulses in the same cycle: start wins; lap discarded.
REQ-020 Outputs SHALL reflect the new state one cycle after the input pulse edge (latency 1).
REQ-021 Prescaler SHALL count 0..CLK_PER_TICK-1 only while enb=1; o_tick=1 for exactly the cycle in which it wraps.
REQ-022 Prescaler SHALL hold its value in STOP, so resuming completes the partial period; SHALL clear to 0 in IDLE.
REQ-023 In RUN or LAP, i_count equal to all-ones SHALL force STOP next cycle, set o_overflow, and suppress o_tick in that cycle.
REQ-024 o_overflow SHALL clear only on entry to IDLE or on reset; start in STOP while o_overflow=1 SHALL be ignored.
REQ-025 o_lap_value SHALL hold its value until the next capture; it SHALL clear to 0 on entry to IDLE.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, init=1, enb=0, tick=0, disp_sel=0, lap_value=0, overflow=0, prescaler=0.
REQ-027 Reset asserted mid-RUN/LAP SHALL discard any partial tick; the first tick after start SHALL occur a full CLK_PER_TICK cycles later.

Configuration
REQ-028 Macro RTC_LAP_EN defined: LAP state and lap capture present as specified.
REQ-029 RTC_LAP_EN undefined: no LAP state; lap in RUN ignored; o_disp_sel and o_lap_value tied to 0; lap in STOP still -> IDLE.

Structure
REQ-030 Package rtc_pkg SHALL hold the state enum typedef, default COUNT_W=24 and default CLK_PER_TICK.
REQ-031 Prescaler SHALL be sub-module rtc_tick_gen (inputs enb, clr; output tick).

Verification (CLK_PER_TICK=4)
REQ-032 Reset, then start pulse -> next cycle init=0, enb=1; o_tick on the 4th, 8th and 12th enabled cycles.
REQ-033 RUN with i_count=0x000123, lap pulse -> o_lap_value=0x000123, disp_sel=1; second lap -> disp_sel=0, enb stays 1.
REQ-034 Start after 2 enabled cycles (STOP), wait 10 cycles, start again -> first tick 2 cycles after resume.
REQ-035 Start and lap in the same cycle during RUN -> STOP, no lap capture; lap in STOP -> IDLE, lap_value=0.
REQ-036 i_count=0xFFFFFF in RUN -> STOP, overflow=1, no tick; start ignored; lap -> IDLE, overflow=0.
REQ-037 Reset mid-LAP -> all outputs at reset values asynchronously, before the next clock edge.
